// File: rtl/lrelu_beats_sequencer_if.sv
// Control/status bundle between the config/DMA path (master) and the LReLU
// beats sequencer (slave). Widths derive from the same kernel/group maxima
// the sequencer is built with, so both ends always agree.
interface lrelu_beats_sequencer_if #(
    parameter int MEMBERS = 8,
    parameter int KH_MAX  = 7,
    parameter int KW_MAX  = 7
);
    localparam int KH2_MAX     = KH_MAX / 2;
    localparam int KW2_MAX     = KW_MAX / 2;
    localparam int C_MAX       = (KH2_MAX > KW2_MAX) ? KH2_MAX : KW2_MAX;
    localparam int A_SPAN      = (KW_MAX + 1) / 2;
    localparam int B_SPAN      = ((2 * C_MAX + 1) * KW_MAX + MEMBERS - 1) / MEMBERS;
    localparam int BITS_KH2    = $clog2(KH2_MAX + 1);
    localparam int BITS_KW2    = $clog2(KW2_MAX + 1);
    localparam int BITS_CLR_I  = $clog2(C_MAX + 1);
    localparam int BITS_MTB    = $clog2(KH_MAX);
    localparam int BITS_W_ADDR = $clog2((A_SPAN > B_SPAN) ? A_SPAN : B_SPAN);

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [BITS_KH2-1:0]    cfg_kh2;
    logic [BITS_KW2-1:0]    cfg_kw2;
    logic                   en;
    logic [1:0]             w_sel;
    logic [BITS_CLR_I-1:0]  clr_i;
    logic [BITS_MTB-1:0]    mtb;
    logic [BITS_W_ADDR-1:0] w_addr;
    logic                   full;
    logic                   done;
    logic                   busy;

    modport master (
        output cfg_valid, cfg_kh2, cfg_kw2, en,
        input  cfg_ready, w_sel, clr_i, mtb, w_addr, full, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_kh2, cfg_kw2, en,
        output cfg_ready, w_sel, clr_i, mtb, w_addr, full, done, busy
    );
endinterface

// File: rtl/lrelu_beats_sequencer.sv
// LReLU coefficient-load beat sequencer. After a latched per-layer kernel
// config it walks one REG_D beat, the BRAM_A block and the nested BRAM_B
// (clear group / member tile beat / address) block once, then returns to IDLE
// and pulses done. All per-kernel limits come from small elaboration-time
// tables or shifts/compares; there is no runtime divider.
// Assumes KH_MAX and KW_MAX are odd and at least 3.
module lrelu_beats_sequencer #(
    parameter int MEMBERS = 8,
    parameter int KH_MAX  = 7,
    parameter int KW_MAX  = 7
) (
    input  logic                   clk,
    input  logic                   rstn,
    lrelu_beats_sequencer_if.slave bus
);
    localparam int KH2_MAX     = KH_MAX / 2;
    localparam int KW2_MAX     = KW_MAX / 2;
    localparam int C_MAX       = (KH2_MAX > KW2_MAX) ? KH2_MAX : KW2_MAX;
    localparam int A_SPAN      = (KW_MAX + 1) / 2;
    localparam int B_SPAN      = ((2 * C_MAX + 1) * KW_MAX + MEMBERS - 1) / MEMBERS;
    localparam int BITS_KH2    = $clog2(KH2_MAX + 1);
    localparam int BITS_KW2    = $clog2(KW2_MAX + 1);
    localparam int BITS_CLR_I  = $clog2(C_MAX + 1);
    localparam int BITS_MTB    = $clog2(KH_MAX);
    localparam int BITS_W_ADDR = $clog2((A_SPAN > B_SPAN) ? A_SPAN : B_SPAN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REG_D  = 2'd1,
        BRAM_A = 2'd2,
        BRAM_B = 2'd3
    } w_sel_t;

    // Last BRAM_B address of clear group c for half-width kw2:
    // ceil((2c+1)*(2*kw2+1)/MEMBERS) - 1. Only ever evaluated on constants.
    function automatic int b_last_f(int kw2, int c);
        return (((2 * c + 1) * (2 * kw2 + 1) + MEMBERS - 1) / MEMBERS) - 1;
    endfunction

    w_sel_t                 state_q, state_d;
    logic [BITS_KH2-1:0]    kh2_q, kh2_d, kh2_cfg;
    logic [BITS_KW2-1:0]    kw2_q, kw2_d, kw2_cfg;
    logic [BITS_CLR_I-1:0]  clr_q, clr_d;
    logic [BITS_MTB-1:0]    mtb_q, mtb_d;
    logic [BITS_W_ADDR-1:0] addr_q, addr_d;
    logic                   done_q, done_d;

    logic [BITS_W_ADDR-1:0] b_last_lut [KW2_MAX+1][C_MAX+1];
    logic [BITS_W_ADDR-1:0] b_last;
    logic [BITS_CLR_I-1:0]  m_half;
    logic [BITS_MTB-1:0]    m_last;
    logic [BITS_CLR_I-1:0]  c_last;
    logic                   a_end, b_end, m_end, c_end;

    // Clamp the offered half-sizes to the supported maxima; when the port
    // width cannot exceed the maximum the value passes straight through.
    if (((1 << BITS_KH2) - 1) > KH2_MAX) begin : g_kh2_clamp
        assign kh2_cfg = (bus.cfg_kh2 > BITS_KH2'(KH2_MAX)) ? BITS_KH2'(KH2_MAX) : bus.cfg_kh2;
    end else begin : g_kh2_pass
        assign kh2_cfg = bus.cfg_kh2;
    end

    if (((1 << BITS_KW2) - 1) > KW2_MAX) begin : g_kw2_clamp
        assign kw2_cfg = (bus.cfg_kw2 > BITS_KW2'(KW2_MAX)) ? BITS_KW2'(KW2_MAX) : bus.cfg_kw2;
    end else begin : g_kw2_pass
        assign kw2_cfg = bus.cfg_kw2;
    end

    // BRAM_B address limit table, indexed by latched kw2 and current clr_i.
    for (genvar gw = 0; gw <= KW2_MAX; gw++) begin : g_b_kw
        for (genvar gc = 0; gc <= C_MAX; gc++) begin : g_b_c
            assign b_last_lut[gw][gc] = BITS_W_ADDR'(b_last_f(gw, gc));
        end
    end

    assign b_last = b_last_lut[kw2_q][clr_q];

    // M_LAST(c) = min(2c, kh-1) = 2*min(c, kh2).
    assign m_half = (clr_q < BITS_CLR_I'(kh2_q)) ? clr_q : BITS_CLR_I'(kh2_q);
    assign m_last = BITS_MTB'({m_half, 1'b0});

    // C_LAST = max(kw2, kh2); A_LAST = ceil(kw/2) - 1 = kw2.
    assign c_last = (kh2_q > BITS_KH2'(0) && BITS_CLR_I'(kh2_q) > BITS_CLR_I'(kw2_q))
                    ? BITS_CLR_I'(kh2_q) : BITS_CLR_I'(kw2_q);

    assign a_end = (addr_q == BITS_W_ADDR'(kw2_q));
    assign b_end = (addr_q == b_last);
    assign m_end = (mtb_q == m_last);
    assign c_end = (clr_q == c_last);

    // State, latched config and beat counters; reset is synchronous.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            kh2_q   <= '0;
            kw2_q   <= '0;
            clr_q   <= '0;
            mtb_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kh2_q   <= kh2_d;
            kw2_q   <= kw2_d;
            clr_q   <= clr_d;
            mtb_q   <= mtb_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter stepping; nothing moves on a beat without en.
    // NOTE: every target gets a hold/default value first, so no path through
    // the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        kh2_d   = kh2_q;
        kw2_d   = kw2_q;
        clr_d   = clr_q;
        mtb_d   = mtb_q;
        addr_d  = addr_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    state_d = REG_D;
                    kh2_d   = kh2_cfg;
                    kw2_d   = kw2_cfg;
                end
            end
            REG_D: begin
                if (bus.en) begin
                    state_d = BRAM_A;
                    addr_d  = '0;
                end
            end
            BRAM_A: begin
                if (bus.en) begin
                    if (a_end) begin
                        state_d = BRAM_B;
                        addr_d  = '0;
                        clr_d   = '0;
                        mtb_d   = '0;
                    end else begin
                        addr_d = addr_q + BITS_W_ADDR'(1);
                    end
                end
            end
            BRAM_B: begin
                if (bus.en) begin
                    if (!b_end) begin
                        addr_d = addr_q + BITS_W_ADDR'(1);
                    end else begin
                        addr_d = '0;
                        if (!m_end) begin
                            mtb_d = mtb_q + BITS_MTB'(1);
                        end else begin
                            mtb_d = '0;
                            if (!c_end) begin
                                clr_d = clr_q + BITS_CLR_I'(1);
                            end else begin
                                state_d = IDLE;
                                clr_d   = '0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.w_sel     = state_q;
    assign bus.clr_i     = clr_q;
    assign bus.mtb       = mtb_q;
    assign bus.w_addr    = addr_q;
    assign bus.done      = done_q;
    assign bus.full      = (state_q == BRAM_B) && b_end && m_end && c_end;
endmodule

// File: tb/tb_lrelu_beats_sequencer.sv
// Self-checking bench for lrelu_beats_sequencer. A queue model expands each
// accepted config into its full beat list with plain arithmetic and is
// compared against the DUT every cycle; literal beat lists pin the model.
module tb_lrelu_beats_sequencer;
    localparam int MEMBERS  = 8;
    localparam int KH_MAX   = 7;
    localparam int KW_MAX   = 7;
    localparam int KH2_MAX  = KH_MAX / 2;
    localparam int KW2_MAX  = KW_MAX / 2;
    localparam int BITS_KH2 = $clog2(KH2_MAX + 1);
    localparam int BITS_KW2 = $clog2(KW2_MAX + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lrelu_beats_sequencer_if #(.MEMBERS(MEMBERS), .KH_MAX(KH_MAX), .KW_MAX(KW_MAX)) bus ();

    lrelu_beats_sequencer #(.MEMBERS(MEMBERS), .KH_MAX(KH_MAX), .KW_MAX(KW_MAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic       chk_on   = 1'b0;
    logic       done_due = 1'b0;
    logic [9:0] exp_q [$];
    logic [9:0] log_q [$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Beat tuple {w_sel, clr_i, mtb, w_addr}.
    function automatic logic [9:0] pk(input int ws, input int c, input int m, input int a);
        return {ws[1:0], c[1:0], m[2:0], a[2:0]};
    endfunction

    // Expand one config into its beat list straight from the sequencing rules.
    task automatic model_build(input int kh2, input int kw2);
        int kw, kh, cl, ml, bl;
        kw = 2 * kw2 + 1;
        kh = 2 * kh2 + 1;
        cl = (kw2 > kh2) ? kw2 : kh2;
        exp_q.push_back(pk(1, 0, 0, 0));
        for (int a = 0; a < (kw + 1) / 2; a++) exp_q.push_back(pk(2, 0, 0, a));
        for (int c = 0; c <= cl; c++) begin
            ml = (2 * c < kh - 1) ? 2 * c : kh - 1;
            bl = ((2 * c + 1) * kw + MEMBERS - 1) / MEMBERS - 1;
            for (int m = 0; m <= ml; m++)
                for (int w = 0; w <= bl; w++)
                    exp_q.push_back(pk(3, c, m, w));
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic       was_idle;
        logic [9:0] h;
        int         k2, w2;
        if (chk_on) begin
            check("done", int'(bus.done), int'(done_due));
            done_due = 1'b0;
            was_idle = (exp_q.size() == 0);
            if (was_idle) begin
                check("idle_w_sel", int'(bus.w_sel), 0);
                check("idle_busy", int'(bus.busy), 0);
                check("idle_cfg_ready", int'(bus.cfg_ready), 1);
                check("idle_full", int'(bus.full), 0);
                check("idle_counters", int'({bus.clr_i, bus.mtb, bus.w_addr}), 0);
            end else begin
                h = exp_q[0];
                check("w_sel", int'(bus.w_sel), int'(h[9:8]));
                check("clr_i", int'(bus.clr_i), int'(h[7:6]));
                check("mtb", int'(bus.mtb), int'(h[5:3]));
                check("w_addr", int'(bus.w_addr), int'(h[2:0]));
                check("full", int'(bus.full), int'(exp_q.size() == 1));
                check("busy", int'(bus.busy), 1);
                check("cfg_ready", int'(bus.cfg_ready), 0);
            end
            if (bus.busy && bus.en) log_q.push_back({bus.w_sel, bus.clr_i, bus.mtb, bus.w_addr});
            if (!rstn) begin
                exp_q.delete();
            end else if (was_idle) begin
                if (bus.cfg_valid) begin
                    k2 = (int'(bus.cfg_kh2) > KH2_MAX) ? KH2_MAX : int'(bus.cfg_kh2);
                    w2 = (int'(bus.cfg_kw2) > KW2_MAX) ? KW2_MAX : int'(bus.cfg_kw2);
                    model_build(k2, w2);
                end
            end else if (bus.en) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_due = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int kh2, input int kw2);
        bus.cfg_valid = 1'b1;
        bus.cfg_kh2   = BITS_KH2'(kh2);
        bus.cfg_kw2   = BITS_KW2'(kw2);
        log_q.delete();
        step();
        bus.cfg_valid = 1'b0;
    endtask

    // mode 0: en always high; 1: random en gaps plus a hold on the final beat;
    // 2: en high with a stray config offer mid-sequence.
    task automatic run_until_done(input int mode, input string tag);
        int holds;
        bit seen;
        holds = 0;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mode == 1) begin
                if (bus.full && holds < 3) begin
                    bus.en = 1'b0;
                    holds++;
                end else begin
                    bus.en = 1'($urandom_range(0, 1));
                end
            end else begin
                bus.en = 1'b1;
            end
            if (mode == 2) begin
                bus.cfg_valid = (i == 4);
                bus.cfg_kh2   = BITS_KH2'(3);
                bus.cfg_kw2   = BITS_KW2'(3);
            end
            step();
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        check({tag, "_done_seen"}, int'(seen), 1);
        if (mode == 1) check({tag, "_full_hold"}, holds, 3);
    endtask

    task automatic check_log(input string tag, input logic [9:0] lit [$]);
        check({tag, "_beats"}, log_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < log_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), int'(log_q[i]), int'(lit[i]));
    endtask

    logic [9:0] lit33 [$];
    logic [9:0] lit13 [$];
    logic [9:0] lit51 [$];

    initial begin
        int t_full, t_done, t_regd;

        bus.cfg_valid = 1'b0;
        bus.cfg_kh2   = '0;
        bus.cfg_kw2   = '0;
        bus.en        = 1'b0;

        lit33 = '{};
        lit33.push_back(pk(1, 0, 0, 0));
        lit33.push_back(pk(2, 0, 0, 0)); lit33.push_back(pk(2, 0, 0, 1));
        lit33.push_back(pk(3, 0, 0, 0));
        lit33.push_back(pk(3, 1, 0, 0)); lit33.push_back(pk(3, 1, 0, 1));
        lit33.push_back(pk(3, 1, 1, 0)); lit33.push_back(pk(3, 1, 1, 1));
        lit33.push_back(pk(3, 1, 2, 0)); lit33.push_back(pk(3, 1, 2, 1));

        lit13 = '{};
        lit13.push_back(pk(1, 0, 0, 0));
        lit13.push_back(pk(2, 0, 0, 0)); lit13.push_back(pk(2, 0, 0, 1));
        lit13.push_back(pk(3, 0, 0, 0));
        lit13.push_back(pk(3, 1, 0, 0)); lit13.push_back(pk(3, 1, 0, 1));

        lit51 = '{};
        lit51.push_back(pk(1, 0, 0, 0));
        lit51.push_back(pk(2, 0, 0, 0));
        lit51.push_back(pk(3, 0, 0, 0));
        for (int m = 0; m <= 2; m++) lit51.push_back(pk(3, 1, m, 0));
        for (int m = 0; m <= 4; m++) lit51.push_back(pk(3, 2, m, 0));

        // Reset state.
        rstn = 1'b0;
        step();
        step();
        check("rst_w_sel", int'(bus.w_sel), 0);
        check("rst_counters", int'({bus.clr_i, bus.mtb, bus.w_addr}), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        check("rst_full", int'(bus.full), 0);
        rstn   = 1'b1;
        chk_on = 1'b1;
        step();

        // 3x3, en continuous.
        offer(1, 1);
        run_until_done(0, "k3x3");
        check_log("k3x3", lit33);
        check("k3x3_ready_after", int'(bus.cfg_ready), 1);

        // 1x3.
        offer(0, 1);
        run_until_done(0, "k1x3");
        check_log("k1x3", lit13);

        // 5x1.
        offer(2, 0);
        run_until_done(0, "k5x1");
        check_log("k5x1", lit51);

        // 3x3 with random en gaps.
        offer(1, 1);
        run_until_done(1, "k3x3_gaps");
        check_log("k3x3_gaps", lit33);

        // 3x3 with a config offered while busy.
        offer(1, 1);
        run_until_done(2, "k3x3_stray");
        check_log("k3x3_stray", lit33);

        // kh2 offered as 7 truncates/clamps to 3: 7x3 kernel -> 41 beats.
        offer(7, 1);
        run_until_done(0, "k7x3");
        check("k7x3_beats", log_q.size(), 41);
        if (log_q.size() > 0) check("k7x3_last", int'(log_q[log_q.size()-1]), int'(pk(3, 3, 6, 2)));

        // Reset during BRAM_B aborts without done.
        offer(1, 1);
        bus.en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.w_sel == 2'd3) break;
        end
        check("abort_in_b", int'(bus.w_sel), 3);
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("abort_w_sel", int'(bus.w_sel), 0);
        check("abort_counters", int'({bus.clr_i, bus.mtb, bus.w_addr}), 0);
        check("abort_done", int'(bus.done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", int'(bus.done), 0);
        end
        bus.en = 1'b0;

        // Back-to-back with cfg_valid held: REG_D two cycles after full beat.
        bus.cfg_valid = 1'b1;
        bus.cfg_kh2   = BITS_KH2'(0);
        bus.cfg_kw2   = BITS_KW2'(1);
        bus.en        = 1'b1;
        t_full = -1;
        t_done = -1;
        t_regd = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.full && t_full < 0) t_full = i;
            step();
            if (bus.done && t_done < 0) t_done = i + 1;
            if (t_done >= 0 && bus.w_sel == 2'd1 && t_regd < 0) begin
                t_regd = i + 1;
                bus.cfg_valid = 1'b0;
                break;
            end
        end
        bus.cfg_valid = 1'b0;
        check("b2b_full_seen", int'(t_full >= 0), 1);
        check("b2b_done_gap", t_done - t_full, 1);
        check("b2b_regd_gap", t_regd - t_full, 2);
        run_until_done(0, "b2b_second");

        step();
        step();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lrelu_beats_sequencer.md
Name: lrelu_beats_sequencer

Overview:
- Parametrised successor to the LReLU beats counter. Generates the per-beat write-select, clear-index, member-tile-beat and BRAM address sequence for LReLU coefficient loading.
- Generalised to non-square kernels (independent kh, kw).
- Adds a latched per-layer config handshake, an explicit IDLE state, one-shot (non-cyclic) sequencing and a registered done pulse.
- Sits between the config/DMA control path and the LReLU coefficient register/BRAM write logic.

Parameters:
- MEMBERS, 8, cores per group; divisor in BRAM_B beat count.
- KH_MAX, 7, max kernel height (odd).
- KW_MAX, 7, max kernel width (odd).
- BITS_KH2, $clog2(KH_MAX/2+1), width of kh2.
- BITS_KW2, $clog2(KW_MAX/2+1), width of kw2.
- BITS_CLR_I, $clog2(max(KH_MAX,KW_MAX)/2+1), width of clr_i.
- BITS_MTB, $clog2(KH_MAX), width of mtb.
- BITS_W_ADDR, $clog2(max(ceil(KW_MAX/2), ceil(max(KH_MAX,KW_MAX)*KW_MAX/MEMBERS))), width of w_addr.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset, synchronous, active-low.
- cfg_valid, in, 1: config offered.
- cfg_ready, out, 1: config accepted when high with cfg_valid; equals (w_sel==IDLE).
- cfg_kh2, in, BITS_KH2: (kh-1)/2.
- cfg_kw2, in, BITS_KW2: (kw-1)/2.
- en, in, 1: advance one beat.
- w_sel, out, 2: 0 IDLE, 1 REG_D, 2 BRAM_A, 3 BRAM_B.
- clr_i, out, BITS_CLR_I: clear-group index.
- mtb, out, BITS_MTB: member tile beat within clr_i.
- w_addr, out, BITS_W_ADDR: beat address within current A/B block.
- full, out, 1: combinational; current beat is the final beat of the sequence.
- done, out, 1: registered one-cycle pulse after the final beat is consumed.
- busy, out, 1: w_sel != IDLE.

Behaviour:
- Reset (rstn=0 at posedge): w_sel=IDLE, clr_i=0, mtb=0, w_addr=0, done=0, latched kh2=kw2=0. Reset mid-sequence aborts to IDLE with no done pulse.
- Config latch: on cfg_valid && cfg_ready, latch kh2 = min(cfg_kh2, KH_MAX/2) and kw2 = min(cfg_kw2, KW_MAX/2), then w_sel <- REG_D. Counters are already 0. cfg_valid while busy is ignored; latched values stay stable until the next IDLE.
- Derived values (from latched config):
  - kw = 2*kw2+1, kh = 2*kh2+1.
  - C_LAST = max(kw2, kh2).
  - M_LAST(c) = min(2c, kh-1).
  - A_LAST = ceil(kw/2)-1.
  - B_LAST(c) = ceil((2c+1)*kw/MEMBERS)-1.
  - All of these are built from generate-time LUTs indexed by kw2/kh2/clr_i. No runtime divider.
- Every state advances only in cycles where en=1. With en=0, all outputs hold.
- REG_D: one beat. Then -> BRAM_A with w_addr=0.
- BRAM_A: w_addr counts 0..A_LAST. At A_LAST -> BRAM_B with w_addr=0, clr_i=0, mtb=0.
- BRAM_B: nested counters, innermost first: w_addr 0..B_LAST(clr_i), then mtb 0..M_LAST(clr_i), then clr_i 0..C_LAST. Each inner counter wraps to 0 when the next outer counter increments.
- full = (w_sel==BRAM_B) && w_addr==B_LAST(clr_i) && mtb==M_LAST(clr_i) && clr_i==C_LAST. It is asserted regardless of en.
- Final beat (full && en): next cycle w_sel=IDLE, all counters 0, done=1 for exactly one cycle.
- Back-to-back: if cfg_valid is held high, the new config is accepted in the cycle done=1 (IDLE lasts at least one cycle). The REG_D beat follows the cycle after.
- clr_i/mtb/w_addr hold 0 outside BRAM_B, except w_addr counts in BRAM_A.
- Total en-beats per sequence = 1 + (A_LAST+1) + sum over c=0..C_LAST of (M_LAST(c)+1)*(B_LAST(c)+1).

Test Plan:
- 3x3 (kh2=kw2=1), MEMBERS=8, en=1 continuously -> 10 beats:
  - w_sel sequence 1, 2,2, 3×7.
  - B beats: (clr_i,mtb,w_addr) = (0,0,0), (1,0,0),(1,0,1),(1,1,0),(1,1,1),(1,2,0),(1,2,1).
  - full only on the 10th beat; done one cycle later; cfg_ready high after.
- 1x3 (kh2=0, kw2=1) -> 6 beats: REG_D, A(0,1), B(0,0,0), (1,0,0), (1,0,1).
- 5x1 (kh2=2, kw2=0) -> 11 beats: A_LAST=0; B has 1+3+5=9 beats, all w_addr=0; mtb ranges 0, 0..2, 0..4.
- Random en gaps in the 3x3 case -> identical beat sequence; outputs frozen while en=0; full stays high across en=0 on the last beat.
- cfg_valid pulsed mid-sequence with kh2=3 -> ignored, sequence unchanged. cfg_kh2=7 with KH_MAX=7 -> clamped to 3.
- rstn=0 during BRAM_B -> next cycle IDLE, counters 0, no done. cfg_valid held across done -> second sequence begins with REG_D two cycles after the first full beat.
